key_input_port: RTL

// - Memory-mapped input peripheral on the CPU data bus; it is the read-side counterpart of the write-only display port at 16'hFFFF.
// - Synchronises and debounces the board's push-buttons and slide switches.
// - Queues key press/release events in a small FIFO. The CPU polls the FIFO by reading ADDR and acknowledges events by writing ADDR.

---
 rtl/key_input_port_pkg.sv | 15 +
 rtl/key_input_port_debounce_line.sv | 35 +++
 rtl/key_input_port.sv | 100 ++++++++++
 3 files changed

// File: rtl/key_input_port_pkg.sv
// key_input_port_pkg: bus address, status-word field positions, command bits and event layout.
package key_input_port_pkg;
   localparam logic [15:0] KEY_PORT_ADDR = 16'hFFFE;
   localparam int VALID_BIT = 31;
   localparam int OVF_BIT = 30;
   localparam int CNT_LSB = 26;
   localparam int SW_LSB = 16;
   localparam int CMD_POP = 0;
   localparam int CMD_CLR = 1;
   typedef struct packed {
      logic press;
      logic [2:0] zero;
      logic [3:0] idx;
   } key_event_t;
endpackage

// File: rtl/key_input_port_debounce_line.sv
// debounce_line: two-flop synchroniser plus stability counter; change pulses for one cycle when level flips.
module debounce_line #(
   parameter int CYCLES = 500000,
   parameter logic RESET_LEVEL = 1'b0
) (
   input logic clock,
   input logic reset_n,
   input logic raw,
   output logic level,
   output logic change
);
   localparam int CW = CYCLES > 1 ? $clog2(CYCLES) : 1;
   logic s1, s2;
   logic [CW-1:0] cnt;
   always_ff @(posedge clock)
      if (!reset_n) begin
         s1 <= RESET_LEVEL;
         s2 <= RESET_LEVEL;
         level <= RESET_LEVEL;
         cnt <= '0;
         change <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         change <= 1'b0;
         if (s2 == level)
            cnt <= '0;
         else if (cnt == CW'(CYCLES - 1)) begin
            level <= s2;
            cnt <= '0;
            change <= 1'b1;
         end else
            cnt <= cnt + 1'b1;
      end
endmodule

// File: rtl/key_input_port.sv
// key_input_port: memory-mapped, debounced push-button/switch input port with a key event FIFO.
module key_input_port
   import key_input_port_pkg::*;
#(
   parameter logic [15:0] ADDR = KEY_PORT_ADDR,
   parameter int NKEYS = 4,
   parameter int NSW = 10,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int FIFO_DEPTH = 8
) (
   input logic clock,
   input logic reset_n,
   input logic [NKEYS-1:0] key_raw,
   input logic [NSW-1:0] sw_raw,
   input logic [15:0] address,
   input logic [31:0] data,
   input logic wren,
   output logic [31:0] q,
   output logic hit,
   output logic event_pending
);
   localparam int PW = $clog2(FIFO_DEPTH);
   logic [NKEYS-1:0] key_level, key_change, pending, pending_next, grant;
   logic [NSW-1:0] sw_level, sw_change_unused;
   logic [29:0] data_unused;
   logic grant_valid, clear, pop, full, accept, overflow;
   key_event_t ev, head;
   key_event_t mem [FIFO_DEPTH];
   logic [PW-1:0] rd, wr, wr_addr;
   logic [3:0] count, count_next;
   logic [31:0] word;

   for (genvar k = 0; k < NKEYS; k++) begin : g_key
      debounce_line #(.CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_line (
         .clock(clock), .reset_n(reset_n), .raw(key_raw[k]),
         .level(key_level[k]), .change(key_change[k]));
   end
   for (genvar s = 0; s < NSW; s++) begin : g_sw
      debounce_line #(.CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_line (
         .clock(clock), .reset_n(reset_n), .raw(sw_raw[s]),
         .level(sw_level[s]), .change(sw_change_unused[s]));
   end

   // Descending scan so the lowest pending key ends up granted.
   always_comb begin
      grant = '0;
      grant_valid = 1'b0;
      ev = '0;
      for (int i = NKEYS - 1; i >= 0; i--)
         if (pending[i]) begin
            grant = '0;
            grant[i] = 1'b1;
            grant_valid = 1'b1;
            ev = '{press: ~key_level[i], zero: 3'b000, idx: 4'(i)};
         end
   end

   assign data_unused = data[31:2];
   assign hit = address == ADDR;
   assign clear = hit && wren && data[CMD_CLR];
   assign pop = hit && wren && data[CMD_POP] && !clear && count != 4'd0;
   assign full = count == 4'(FIFO_DEPTH);
   assign accept = grant_valid && (clear || !full || pop);
   assign count_next = clear ? 4'(accept) : count + 4'(accept) - 4'(pop);
   assign pending_next = (pending & ~grant) | key_change;
   assign wr_addr = clear ? '0 : wr;

   always_ff @(posedge clock)
      if (!reset_n) begin
         pending <= '0;
         rd <= '0;
         wr <= '0;
         count <= '0;
         overflow <= 1'b0;
         event_pending <= 1'b0;
      end else begin
         pending <= pending_next;
         count <= count_next;
         event_pending <= count_next != 4'd0;
         rd <= clear ? '0 : rd + PW'(pop);
         wr <= wr_addr + PW'(accept);
         overflow <= !clear && (overflow || (grant_valid && full && !pop));
      end

   always_ff @(posedge clock)
      if (accept) mem[wr_addr] <= ev;

   assign head = count != 4'd0 ? mem[rd] : '0;

   always_comb begin
      word = '0;
      word[VALID_BIT] = count != 4'd0;
      word[OVF_BIT] = overflow;
      word[CNT_LSB +: 4] = count;
      word[SW_LSB +: NSW] = sw_level;
      word[7:0] = head;
   end

   assign q = hit && !wren ? word : '0;
endmodule
